// File: rtl/sc_lives_levels_counter_pkg.sv
// Shared definitions for the lives/levels counter.
//   - CNT_W            : width of the lives and level counters
//   - DEF_*            : default values for the top-level parameters
//   - state_e          : game FSM encoding (also driven on status_Out)
//   - lives_step()     : saturating +/-1 step for the lives counter
package sc_lives_levels_counter_pkg;

   localparam int unsigned CNT_W          = 3;
   localparam int unsigned DEF_INIT_LIVES = 3;
   localparam int unsigned DEF_MAX_LIVES  = 7;
   localparam int unsigned DEF_MAX_LEVEL  = 5;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_LOST = 2'd2,
      ST_WON  = 2'd3
   } state_e;

   // Simultaneous inc and dec cancel out; otherwise step by one, clamped
   // to [0, ceil].
   function automatic logic [CNT_W-1:0] lives_step(
      input logic [CNT_W-1:0] cur,
      input logic             inc,
      input logic             dec,
      input logic [CNT_W-1:0] ceil
   );
      logic [CNT_W-1:0] nxt;
      nxt = cur;
      if (inc && !dec && (cur < ceil)) begin
         nxt = cur + CNT_ONE;
      end else if (dec && !inc && (cur != '0)) begin
         nxt = cur - CNT_ONE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sc_lives_levels_counter_edge.sv
// sc_falling_edge_detector: one-bit falling-edge detector for an active-low
// input. Produces a single-cycle event when the previous sample was 1 and
// the current input is 0.
//   clk        : clock
//   rst        : synchronous active-high reset (previous sample -> 0)
//   sig_in_low : active-low input
//   fall_o     : combinational falling-edge event
module sc_falling_edge_detector (
   input  logic clk,
   input  logic rst,
   input  logic sig_in_low,
   output logic fall_o
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = sig_in_low;
   end

   // Resetting to 0 means an input held low through reset needs a fresh
   // high-then-low transition before it can produce an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   always_comb begin
      fall_o = prev_q & ~sig_in_low;
   end

endmodule

// File: rtl/sc_lives_levels_counter.sv
// sc_lives_levels_counter: game lives/level bookkeeping with a small FSM.
//   SC_LIVESLEVELS_CLOCK_50          : clock
//   SC_LIVESLEVELS_RESET_InHigh      : synchronous active-high reset
//   SC_LIVESLEVELS_startButton_InLow : start/restart request (active low)
//   SC_LIVESLEVELS_vidas_dec_InLow   : lose-one-life strobe (active low)
//   SC_LIVESLEVELS_vidas_inc_InLow   : gain-one-life strobe (active low)
//   SC_LIVESLEVELS_niveles_inc_InLow : level-up strobe (active low)
//   SC_LIVESLEVELS_lives_Out         : current lives
//   SC_LIVESLEVELS_level_Out         : current level
//   SC_LIVESLEVELS_COMPARATOR_LIVES  : lives != 0
//   SC_LIVESLEVELS_COMPARATOR_LEVELS : level == MAX_LEVEL
//   SC_LIVESLEVELS_status_Out        : FSM state (IDLE/PLAY/LOST/WON)
module sc_lives_levels_counter
   import sc_lives_levels_counter_pkg::*;
#(
   parameter int unsigned INIT_LIVES = DEF_INIT_LIVES,
   parameter int unsigned MAX_LIVES  = DEF_MAX_LIVES,
   parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL
) (
   input  logic             SC_LIVESLEVELS_CLOCK_50,
   input  logic             SC_LIVESLEVELS_RESET_InHigh,
   input  logic             SC_LIVESLEVELS_startButton_InLow,
   input  logic             SC_LIVESLEVELS_vidas_dec_InLow,
   input  logic             SC_LIVESLEVELS_vidas_inc_InLow,
   input  logic             SC_LIVESLEVELS_niveles_inc_InLow,
   output logic [CNT_W-1:0] SC_LIVESLEVELS_lives_Out,
   output logic [CNT_W-1:0] SC_LIVESLEVELS_level_Out,
   output logic             SC_LIVESLEVELS_COMPARATOR_LIVES,
   output logic             SC_LIVESLEVELS_COMPARATOR_LEVELS,
   output logic [1:0]       SC_LIVESLEVELS_status_Out
);

   localparam logic [CNT_W-1:0] INIT_LIVES_C = CNT_W'(INIT_LIVES);
   localparam logic [CNT_W-1:0] MAX_LIVES_C  = CNT_W'(MAX_LIVES);
   localparam logic [CNT_W-1:0] MAX_LEVEL_C  = CNT_W'(MAX_LEVEL);

   logic clk;
   logic rst;
   logic start_ev;
   logic dec_ev;
   logic inc_ev;
   logic lvl_ev;

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] lives_q;
   logic [CNT_W-1:0] lives_d;
   logic [CNT_W-1:0] level_q;
   logic [CNT_W-1:0] level_d;

   assign clk = SC_LIVESLEVELS_CLOCK_50;
   assign rst = SC_LIVESLEVELS_RESET_InHigh;

   sc_falling_edge_detector u_start_edge (
      .clk        (clk),
      .rst        (rst),
      .sig_in_low (SC_LIVESLEVELS_startButton_InLow),
      .fall_o     (start_ev)
   );

   sc_falling_edge_detector u_dec_edge (
      .clk        (clk),
      .rst        (rst),
      .sig_in_low (SC_LIVESLEVELS_vidas_dec_InLow),
      .fall_o     (dec_ev)
   );

   sc_falling_edge_detector u_inc_edge (
      .clk        (clk),
      .rst        (rst),
      .sig_in_low (SC_LIVESLEVELS_vidas_inc_InLow),
      .fall_o     (inc_ev)
   );

   sc_falling_edge_detector u_lvl_edge (
      .clk        (clk),
      .rst        (rst),
      .sig_in_low (SC_LIVESLEVELS_niveles_inc_InLow),
      .fall_o     (lvl_ev)
   );

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lives_q <= INIT_LIVES_C;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         level_q <= level_d;
      end
   end

   // Next-state logic. Exit checks look at the registered counters, so the
   // transition lands one cycle after the terminal value is reached; the
   // lives check comes first so losing wins a tie.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ev) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (start_ev) begin
               state_d = ST_PLAY;
            end else if (lives_q == '0) begin
               state_d = ST_LOST;
            end else if (level_q == MAX_LEVEL_C) begin
               state_d = ST_WON;
            end
         end
         ST_LOST, ST_WON: begin
            if (start_ev) state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter update. A start event reloads from any state and discards other
   // same-cycle events. Counters only move on PLAY cycles that are not
   // leaving PLAY, which also keeps them frozen in LOST/WON.
   always_comb begin
      lives_d = lives_q;
      level_d = level_q;
      if (start_ev) begin
         lives_d = INIT_LIVES_C;
         level_d = '0;
      end else if ((state_q == ST_PLAY) && (lives_q != '0) &&
                   (level_q != MAX_LEVEL_C)) begin
         lives_d = lives_step(lives_q, inc_ev, dec_ev, MAX_LIVES_C);
         if (lvl_ev && (level_q < MAX_LEVEL_C)) begin
            level_d = level_q + CNT_ONE;
         end
      end
   end

   // Outputs
   always_comb begin
      SC_LIVESLEVELS_status_Out        = state_q;
      SC_LIVESLEVELS_lives_Out         = lives_q;
      SC_LIVESLEVELS_level_Out         = level_q;
      SC_LIVESLEVELS_COMPARATOR_LIVES  = (lives_q != '0);
      SC_LIVESLEVELS_COMPARATOR_LEVELS = (level_q == MAX_LEVEL_C);
   end

endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Testbench for sc_lives_levels_counter: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural game model.
module tb_sc_lives_levels_counter;

   localparam int INIT_LIVES = 3;
   localparam int MAX_LIVES  = 7;
   localparam int MAX_LEVEL  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_n = 1'b1;
   logic       dec_n = 1'b1;
   logic       inc_n = 1'b1;
   logic       lvl_n = 1'b1;
   logic [2:0] lives_o;
   logic [2:0] level_o;
   logic       cmp_lives;
   logic       cmp_levels;
   logic [1:0] status_o;

   int checks = 0;
   int passes = 0;

   // Behavioural model state
   int m_state = 0;
   int m_lives = INIT_LIVES;
   int m_level = 0;
   bit m_prev_start = 0, m_prev_dec = 0, m_prev_inc = 0, m_prev_lvl = 0;

   always #5 clk = ~clk;

   sc_lives_levels_counter #(
      .INIT_LIVES (INIT_LIVES),
      .MAX_LIVES  (MAX_LIVES),
      .MAX_LEVEL  (MAX_LEVEL)
   ) dut (
      .SC_LIVESLEVELS_CLOCK_50          (clk),
      .SC_LIVESLEVELS_RESET_InHigh      (rst),
      .SC_LIVESLEVELS_startButton_InLow (start_n),
      .SC_LIVESLEVELS_vidas_dec_InLow   (dec_n),
      .SC_LIVESLEVELS_vidas_inc_InLow   (inc_n),
      .SC_LIVESLEVELS_niveles_inc_InLow (lvl_n),
      .SC_LIVESLEVELS_lives_Out         (lives_o),
      .SC_LIVESLEVELS_level_Out         (level_o),
      .SC_LIVESLEVELS_COMPARATOR_LIVES  (cmp_lives),
      .SC_LIVESLEVELS_COMPARATOR_LEVELS (cmp_levels),
      .SC_LIVESLEVELS_status_Out        (status_o)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Game rules applied to the inputs present at a rising edge.
   task automatic model_edge();
      bit s, d, i, l;
      if (rst) begin
         m_state = 0; m_lives = INIT_LIVES; m_level = 0;
         m_prev_start = 0; m_prev_dec = 0; m_prev_inc = 0; m_prev_lvl = 0;
         return;
      end
      s = m_prev_start && !start_n;
      d = m_prev_dec   && !dec_n;
      i = m_prev_inc   && !inc_n;
      l = m_prev_lvl   && !lvl_n;
      m_prev_start = start_n; m_prev_dec = dec_n;
      m_prev_inc = inc_n;     m_prev_lvl = lvl_n;
      if (s) begin
         m_state = 1; m_lives = INIT_LIVES; m_level = 0;
      end else if (m_state == 1) begin
         if (m_lives == 0) m_state = 2;
         else if (m_level == MAX_LEVEL) m_state = 3;
         else begin
            m_lives = m_lives + int'(i) - int'(d);
            if (m_lives < 0) m_lives = 0;
            if (m_lives > MAX_LIVES) m_lives = MAX_LIVES;
            if (l && m_level < MAX_LEVEL) m_level = m_level + 1;
         end
      end
   endtask

   // One clock: update model at the edge, compare all outputs 1 ns later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("lives",      int'(lives_o),    m_lives);
      check("level",      int'(level_o),    m_level);
      check("status",     int'(status_o),   m_state);
      check("cmp_lives",  int'(cmp_lives),  int'(m_lives != 0));
      check("cmp_levels", int'(cmp_levels), int'(m_level == MAX_LEVEL));
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   // which: 0 start, 1 dec, 2 inc, 3 level. Low for one cycle, then high.
   task automatic pulse(input int which);
      case (which)
         0: start_n = 1'b0;
         1: dec_n   = 1'b0;
         2: inc_n   = 1'b0;
         default: lvl_n = 1'b0;
      endcase
      cyc();
      start_n = 1'b1; dec_n = 1'b1; inc_n = 1'b1; lvl_n = 1'b1;
      cyc();
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(2);
      check("rst_status", int'(status_o), 0);
      check("rst_lives",  int'(lives_o), 3);
      check("rst_level",  int'(level_o), 0);
      check("rst_cmpl",   int'(cmp_lives), 1);
      check("rst_cmplev", int'(cmp_levels), 0);

      // Start -> PLAY
      pulse(0);
      check("start_status", int'(status_o), 1);
      check("start_lives",  int'(lives_o), 3);

      // Lose all lives
      pulse(1); check("dec1", int'(lives_o), 2);
      pulse(1); check("dec2", int'(lives_o), 1);
      dec_n = 1'b0; cyc();
      check("dec3", int'(lives_o), 0);
      check("dec3_still_play", int'(status_o), 1);
      dec_n = 1'b1; cyc();
      check("lost_status", int'(status_o), 2);
      check("lost_cmpl",   int'(cmp_lives), 0);
      pulse(1);
      check("dec_in_lost", int'(lives_o), 0);

      // Climb to the winning level
      pulse(0);
      for (int n = 0; n < 4; n++) pulse(3);
      lvl_n = 1'b0; cyc();
      check("lvl5", int'(level_o), 5);
      check("lvl5_cmp", int'(cmp_levels), 1);
      lvl_n = 1'b1; cyc();
      check("won_status", int'(status_o), 3);
      pulse(3);
      check("lvl6_ignored", int'(level_o), 5);

      // Simultaneous dec+inc held, then inc held at the ceiling
      pulse(0);
      dec_n = 1'b0; inc_n = 1'b0;
      cycles(10);
      check("pair_hold", int'(lives_o), 3);
      dec_n = 1'b1; inc_n = 1'b1; cyc();
      for (int n = 0; n < 4; n++) pulse(2);
      check("inc_to_max", int'(lives_o), 7);
      inc_n = 1'b0; cycles(5);
      check("inc_sat", int'(lives_o), 7);
      inc_n = 1'b1; cyc();

      // Start held low through reset
      start_n = 1'b0; rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(3);
      check("held_start_idle", int'(status_o), 0);
      start_n = 1'b1; cyc();
      start_n = 1'b0; cyc();
      check("restart_after_hold", int'(status_o), 1);
      start_n = 1'b1; cyc();

      // Reset coinciding with a dec event
      dec_n = 1'b0; rst = 1'b1;
      cyc();
      check("rst_dec_lives",  int'(lives_o), 3);
      check("rst_dec_status", int'(status_o), 0);
      rst = 1'b0; dec_n = 1'b1;
      cycles(2);

      // Restart mid-play with events in the same cycle
      pulse(0);
      pulse(1);
      start_n = 1'b0; dec_n = 1'b0; lvl_n = 1'b0; cyc();
      check("restart_discard_lives", int'(lives_o), 3);
      check("restart_discard_level", int'(level_o), 0);
      start_n = 1'b1; dec_n = 1'b1; lvl_n = 1'b1; cyc();

      // Randomized play
      for (int n = 0; n < 1500; n++) begin
         rst     = ($urandom_range(99) == 0);
         start_n = ($urandom_range(24) != 0);
         dec_n   = ($urandom_range(2) != 0);
         inc_n   = ($urandom_range(2) != 0);
         lvl_n   = ($urandom_range(3) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
